// File: rtl/demux_pkg.sv
// Shared constants and types for the four-lane byte dispatcher.
package demux_pkg;

  localparam int DW     = 8;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  localparam logic [LANE_W-1:0] LANE0 = 2'd0;
  localparam logic [LANE_W-1:0] LANE1 = 2'd1;
  localparam logic [LANE_W-1:0] LANE2 = 2'd2;
  localparam logic [LANE_W-1:0] LANE3 = 2'd3;

  // Per-lane holding slot occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

endpackage

// File: rtl/demux_lane_slot.sv
// One-entry registered holding slot for a single output lane.
//
// Handshake: a byte sits in the slot while valid is high; it leaves when
// valid && ready are both high at a rising edge. The slot is "free" when it is
// empty or draining this cycle, so a load and a drain may share one edge and
// the lane streams with no bubble.
module demux_lane_slot
  import demux_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          free,
  output lane_state_e   state
);

  lane_state_e   state_q;
  logic [DW-1:0] data_q;

  // Occupancy and payload: load wins over drain; data holds after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else if (load) begin
      state_q <= FULL;
      data_q  <= din;
    end else if (state_q == FULL && ready) begin
      state_q <= EMPTY;
    end
  end

  assign valid = (state_q == FULL);
  assign data  = data_q;
  assign free  = (state_q == EMPTY) || ready;
  assign state = state_q;

endmodule

// File: rtl/demux4_dispatch.sv
// Four-lane byte dispatcher: steers one byte to the addressed lane, or to all
// four lanes on broadcast, through per-lane one-entry holding slots.
//
// Optional feature macro: DEMUX_STATS_EN adds saturating per-lane
// accepted-byte counters on stat_lane0..stat_lane3.
//
// Input handshake: a byte is accepted when in_valid && in_ready at a rising
// edge. in_ready is combinational from out_ready (lane free = empty or
// draining). Broadcast is all-or-nothing: it waits until all four lanes are
// free. There is no combinational path from in_data to any out_data.
module demux4_dispatch
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [LANE_W-1:0] in_dest,
  input  logic              in_bcast,
  output logic [LANES-1:0]  out_valid,
  input  logic [LANES-1:0]  out_ready,
  output logic [DW-1:0]     out_data0,
  output logic [DW-1:0]     out_data1,
  output logic [DW-1:0]     out_data2,
  output logic [DW-1:0]     out_data3
`ifdef DEMUX_STATS_EN
  ,
  output logic [7:0]        stat_lane0,
  output logic [7:0]        stat_lane1,
  output logic [7:0]        stat_lane2,
  output logic [7:0]        stat_lane3
`endif
);

  logic [LANES-1:0] lane_free;
  logic [LANES-1:0] lane_load;
  logic [DW-1:0]    lane_data [LANES];
  lane_state_e      lane_state [LANES];
  logic             accept;

  // Readiness: broadcast needs every lane free, unicast only the addressed one.
  always_comb begin
    in_ready = 1'b0;
    if (in_bcast) in_ready = &lane_free;
    else          in_ready = lane_free[in_dest];
  end

  assign accept = in_valid && in_ready;

  // Destination decode into per-lane load strobes.
  always_comb begin
    lane_load = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_load[i] = accept && (in_bcast || (in_dest == LANE_W'(i)));
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (lane_load[g]),
      .din   (in_data),
      .ready (out_ready[g]),
      .valid (out_valid[g]),
      .data  (lane_data[g]),
      .free  (lane_free[g]),
      .state (lane_state[g])
    );
  end

  assign out_data0 = lane_data[LANE0];
  assign out_data1 = lane_data[LANE1];
  assign out_data2 = lane_data[LANE2];
  assign out_data3 = lane_data[LANE3];

`ifdef DEMUX_STATS_EN
  logic [7:0] stat_cnt [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_stat
    // Saturating count of bytes loaded into this lane.
    always_ff @(posedge clk) begin
      if (rst) begin
        stat_cnt[g] <= '0;
      end else if (lane_load[g] && (stat_cnt[g] != 8'hFF)) begin
        stat_cnt[g] <= stat_cnt[g] + 8'd1;
      end
    end
  end

  assign stat_lane0 = stat_cnt[0];
  assign stat_lane1 = stat_cnt[1];
  assign stat_lane2 = stat_cnt[2];
  assign stat_lane3 = stat_cnt[3];
`endif

endmodule

// File: tb/tb_demux4_dispatch.sv
// Directed self-checking bench for demux4_dispatch.
module tb_demux4_dispatch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       in_bcast;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_STATS_EN
  logic [7:0] stat_lane0, stat_lane1, stat_lane2, stat_lane3;
`endif

  int errors = 0;
  int checks = 0;

  demux4_dispatch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX_STATS_EN
    ,
    .stat_lane0 (stat_lane0),
    .stat_lane1 (stat_lane1),
    .stat_lane2 (stat_lane2),
    .stat_lane3 (stat_lane3)
`endif
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane_data(input int idx);
    case (idx)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    in_dest  = 2'd0;
    in_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_dest = 2'd0;
    in_bcast = 1'b0; out_ready = 4'b0000;
    step();
    step();
    check_vec("reset_out_valid", {4'b0, out_valid}, 8'h00);
    check_vec("reset_data0", out_data0, 8'h00);
    check_vec("reset_data1", out_data1, 8'h00);
    check_vec("reset_data2", out_data2, 8'h00);
    check_vec("reset_data3", out_data3, 8'h00);
    rst = 1'b0;
    idle();
    #1;
    check_vec("reset_in_ready", {7'b0, in_ready}, 8'h01);
    step();
    check_vec("reset_no_load", {4'b0, out_valid}, 8'h00);
  endtask

  task automatic test_unicast();
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 2'd2; out_ready = 4'b0000;
    #1;
    check_vec("uni_ready_empty", {7'b0, in_ready}, 8'h01);
    step();
    check_vec("uni_out_valid", {4'b0, out_valid}, 8'h04);
    check_vec("uni_data2", out_data2, 8'hA5);
    in_data = 8'h3C;
    #1;
    check_vec("uni_ready_full", {7'b0, in_ready}, 8'h00);
    step();
    check_vec("uni_stall_valid", {4'b0, out_valid}, 8'h04);
    check_vec("uni_stall_data", out_data2, 8'hA5);
    out_ready = 4'b0100;
    #1;
    check_vec("uni_ready_drain", {7'b0, in_ready}, 8'h01);
    step();
    check_vec("uni_refill_valid", {4'b0, out_valid}, 8'h04);
    check_vec("uni_refill_data", out_data2, 8'h3C);
    idle();
    step();
    check_vec("uni_drained_valid", {4'b0, out_valid}, 8'h00);
    check_vec("uni_drained_hold", out_data2, 8'h3C);
    out_ready = 4'b0000;
  endtask

  task automatic test_isolation();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 8'h55; in_dest = 2'd1;
    step();
    in_data = 8'h11; in_dest = 2'd0;
    #1;
    check_vec("iso_ready_lane0", {7'b0, in_ready}, 8'h01);
    step();
    in_data = 8'h22; in_dest = 2'd3;
    #1;
    check_vec("iso_ready_lane3", {7'b0, in_ready}, 8'h01);
    step();
    idle();
    #1;
    check_vec("iso_out_valid", {4'b0, out_valid}, 8'h0B);
    check_vec("iso_data0", out_data0, 8'h11);
    check_vec("iso_data1", out_data1, 8'h55);
    check_vec("iso_data3", out_data3, 8'h22);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check_vec("iso_drain_all", {4'b0, out_valid}, 8'h00);
  endtask

  task automatic test_broadcast();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h7E; in_dest = 2'd1;
    #1;
    check_vec("bc_ready_empty", {7'b0, in_ready}, 8'h01);
    step();
    idle();
    #1;
    check_vec("bc_out_valid", {4'b0, out_valid}, 8'h0F);
    for (int i = 0; i < 4; i++) check_vec($sformatf("bc_data%0d", i), lane_data(i), 8'h7E);
    out_ready = 4'b0111;
    step();
    out_ready = 4'b0000;
    check_vec("bc_lane3_left", {4'b0, out_valid}, 8'h08);
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h99;
    #1;
    check_vec("bc_ready_blocked", {7'b0, in_ready}, 8'h00);
    step();
    idle();
    #1;
    check_vec("bc_blocked_valid", {4'b0, out_valid}, 8'h08);
    for (int i = 0; i < 4; i++) check_vec($sformatf("bc_blocked_data%0d", i), lane_data(i), 8'h7E);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    check_vec("bc_drain_all", {4'b0, out_valid}, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic [3:0] exp_v;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_bcast = 1'b0;
      in_data = i[7:0]; in_dest = i[1:0];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
      end
      exp_q.push_back(i[7:0]);
      step();
      exp_b = exp_q.pop_front();
      exp_v = 4'b0001 << i[1:0];
      checks++;
      if (out_valid !== exp_v || lane_data(int'(i[1:0])) !== exp_b) begin
        errors++;
        $display("FAIL b2b_lane[%0d]: got valid %b data %h expected valid %b data %h",
                 i, out_valid, lane_data(int'(i[1:0])), exp_v, exp_b);
      end
    end
    idle();
    step();
    check_vec("b2b_final_valid", {4'b0, out_valid}, 8'h00);
`ifdef DEMUX_STATS_EN
    check_vec("b2b_stat0", stat_lane0, 8'd64);
    check_vec("b2b_stat1", stat_lane1, 8'd64);
    check_vec("b2b_stat2", stat_lane2, 8'd64);
    check_vec("b2b_stat3", stat_lane3, 8'd64);
`endif
    out_ready = 4'b0000;
  endtask

  task automatic test_saturation();
`ifdef DEMUX_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_vec("sat_cleared", stat_lane0, 8'h00);
    out_ready = 4'b0001;
    in_valid = 1'b1; in_bcast = 1'b0; in_dest = 2'd0;
    for (int i = 0; i < 300; i++) begin
      in_data = i[7:0];
      step();
    end
    check_vec("sat_stat0", stat_lane0, 8'hFF);
    check_vec("sat_stat1", stat_lane1, 8'h00);
    rst = 1'b1;
    step();
    check_vec("sat_rst_stat0", stat_lane0, 8'h00);
    check_vec("sat_rst_valid", {4'b0, out_valid}, 8'h00);
    rst = 1'b0;
    idle();
    out_ready = 4'b0000;
`endif
  endtask

  initial begin
    idle();
    rst = 1'b1;
    out_ready = 4'b0000;
    test_reset();
    test_unicast();
    test_isolation();
    test_broadcast();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux4_dispatch.md
Name: demux4_dispatch

Overview:
- Inverse of the four-input byte selector: takes one 8-bit byte plus a 2-bit destination and steers it to one of four output lanes, or to all four when broadcast is set.
- Each lane has a one-entry registered holding slot with a valid/ready handshake, so slow consumers stall only the producer, not the whole datapath.
- Sits between the ALU/register-file write path and the four peripheral/register sinks of the 8-bit processor.

Parameters:
- DW, 8, byte width of data path and all lane registers.
- LANES, 4, number of output lanes; fixed at 4, and dest width is 2.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a byte.
- in_ready  output  1  block can accept this cycle (combinational).
- in_data  input  DW  byte to dispatch.
- in_dest  input  2  target lane: 00 = lane0, 01 = lane1, 10 = lane2, 11 = lane3.
- in_bcast  input  1  write all four lanes; in_dest is ignored.
- out_valid  output  4  per-lane slot-full flag; bit i = lane i.
- out_ready  input  4  per-lane consumer ready.
- out_data0..out_data3  output  DW each  lane slot contents.
- stat_lane0..stat_lane3  output  8 each  accepted-byte counters; present only with DEMUX_STATS_EN.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state: on rst sampled high, out_valid = 0000, out_data0..3 = 0, stat counters = 0. rst high mid-transfer discards slot contents; no accept occurs that cycle.
- Lane free: lane i can accept when out_valid[i] = 0 or out_ready[i] = 1 (drain and refill in the same cycle).
- in_ready, unicast (in_bcast = 0): lane free for in_dest.
- in_ready, broadcast (in_bcast = 1): all four lanes free. All-or-nothing; partial broadcast is never performed.
- Accept: in_valid && in_ready at a rising edge.
  - Addressed lane(s) load in_data and set out_valid.
  - Latency: 1 cycle from accept to out_valid high.
- Drain: out_valid[i] && out_ready[i] with no load to lane i clears out_valid[i]. out_data holds its last value; it is not zeroed.
- Simultaneous drain and load on the same lane: the new byte is loaded, out_valid[i] stays 1, and no bubble appears.
- Stability: while out_valid[i] = 1 and out_ready[i] = 0, out_data_i is held stable.
- Isolation: lanes not addressed are unaffected by an accept. A stalled lane never blocks unicast traffic to other lanes.
- in_valid = 0: no state change except drains. in_ready is still driven and is meaningful.
- Combinational paths: in_ready depends on out_ready. There is no combinational path from in_data to out_data.
- Per-lane state: two states, EMPTY and FULL.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load with drain.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined: stat_lane0..3 ports exist.
  - Each counter increments by 1 on every accept that loads its lane; a broadcast increments all four.
  - Counters saturate at 8'hFF and do not wrap.
  - Counters clear on rst.
- Undefined: the stat ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package demux_pkg: DW = 8, LANE_W = 2, lane index constants LANE0..LANE3, and state enum {EMPTY, FULL}.
- Natural sub-module: demux_lane_slot, one holding register plus valid bit with load/drain inputs, instantiated four times. The top level holds only decode, the in_ready logic, and the optional counters.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid = 1 -> out_valid = 0000, all out_data = 00, in_ready = 1 after release, no load.
- Unicast: in_data = 8'hA5, in_dest = 10, out_ready = 0000 -> next cycle out_valid = 0100, out_data2 = A5. A second byte 8'h3C to dest 10 sees in_ready = 0. Raise out_ready[2] -> 3C loads with out_valid[2] held at 1.
- Lane isolation: lane1 full and stalled; send 8'h11 to dest 00 and 8'h22 to dest 11 -> both accepted in consecutive cycles, out_valid = 1011, lane1 data unchanged.
- Broadcast: in_bcast = 1, in_data = 8'h7E, all lanes empty -> out_valid = 1111, all data = 7E. Repeat with lane3 full and not ready -> in_ready = 0, and no lane changes.
- Back-to-back streaming: out_ready = 1111, 256 bytes round-robin over dests 00..11, one per cycle -> in_ready stays 1 and every byte appears once on the correct lane one cycle later. With DEMUX_STATS_EN, each stat = 64.
- Saturation (DEMUX_STATS_EN): 300 accepts to lane0 -> stat_lane0 = FF; rst mid-stream -> 00.
